// File: rtl/bitonic_sort_ctrl_if.sv
// Stream and network-side signals of the bitonic sort sequencer.
//   in_valid/in_ready/in_data     : serial element input stream
//   net_start/net_data_o          : one-cycle launch of a full batch to the network
//   net_data_i                    : sorted batch returned by the network
//   out_valid/out_ready/out_data  : serial sorted output stream
//   out_last                      : marks the final lane of a batch
//   busy                          : sequencer or loader holds work
// The slave modport is the sequencer's view; master is the environment's view.
interface bitonic_sort_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int INDEX = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       in_data;
  logic                   net_start;
  logic [WIDTH*INDEX-1:0] net_data_o;
  logic [WIDTH*INDEX-1:0] net_data_i;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       out_data;
  logic                   out_last;
  logic                   busy;

  modport slave (
    input  in_valid, in_data, out_ready, net_data_i,
    output in_ready, net_start, net_data_o, out_valid, out_data, out_last, busy
  );

  modport master (
    output in_valid, in_data, out_ready, net_data_i,
    input  in_ready, net_start, net_data_o, out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/bitonic_sort_ctrl.sv
// Sequencer for a pipelined bitonic sort network.
// A loader gathers INDEX elements from the input stream, the core launches the
// batch into the network, waits NET_LAT cycles, captures the sorted vector and
// drains it lane 0 first on the output stream. The loader keeps filling the
// next batch while the core is running or draining.
//   clk, rst : clock and synchronous active-high reset
//   bus      : stream/network signals (see bitonic_sort_ctrl_if, slave modport)
module bitonic_sort_ctrl #(
  parameter int WIDTH   = 8,
  parameter int INDEX   = 8,
  parameter int NET_LAT = 6
) (
  input  logic               clk,
  input  logic               rst,
  bitonic_sort_ctrl_if.slave bus
);
  localparam int CW = $clog2(INDEX);
  localparam int LW = $clog2(NET_LAT + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]                  state_q, state_d;
  logic [INDEX-1:0][WIDTH-1:0] loadBuf_q, loadBuf_d;
  logic [CW-1:0]               loadCnt_q, loadCnt_d;
  logic                        loadFull_q, loadFull_d;
  logic [LW-1:0]               latCnt_q, latCnt_d;
  logic [INDEX-1:0][WIDTH-1:0] outBuf_q, outBuf_d;
  logic [CW-1:0]               drainIdx_q, drainIdx_d;

  logic inReady;
  logic inAccept;
  logic launch;
  logic draining;
  logic lastLane;

  always_comb begin
    inReady  = !loadFull_q && !rst;
    inAccept = bus.in_valid && inReady;
    // Launches only happen from IDLE so the network never holds two batches
    // and outBuf_q is never overwritten before it has drained.
    launch   = (state_q == IDLE) && loadFull_q;
    draining = (state_q == DRAIN);
    lastLane = (drainIdx_q == CW'(INDEX - 1));

    state_d    = state_q;
    loadBuf_d  = loadBuf_q;
    loadCnt_d  = loadCnt_q;
    loadFull_d = loadFull_q;
    latCnt_d   = latCnt_q;
    outBuf_d   = outBuf_q;
    drainIdx_d = drainIdx_q;

    if (inAccept) begin
      loadBuf_d[loadCnt_q] = bus.in_data;
      if (loadCnt_q == CW'(INDEX - 1)) begin
        loadCnt_d  = '0;
        loadFull_d = 1'b1;
      end else begin
        loadCnt_d = loadCnt_q + 1'b1;
      end
    end

    // A full loader never accepts, so this cannot collide with the set above.
    if (launch) begin
      loadFull_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (launch) begin
          latCnt_d = LW'(1);
          state_d  = RUN;
        end
      end
      RUN: begin
        if (latCnt_q == LW'(NET_LAT)) begin
          outBuf_d   = bus.net_data_i;
          drainIdx_d = '0;
          state_d    = DRAIN;
        end else begin
          latCnt_d = latCnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (bus.out_ready) begin
          drainIdx_d = drainIdx_q + 1'b1;
          if (lastLane) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      loadBuf_q  <= '0;
      loadCnt_q  <= '0;
      loadFull_q <= 1'b0;
      latCnt_q   <= '0;
      outBuf_q   <= '0;
      drainIdx_q <= '0;
    end else begin
      state_q    <= state_d;
      loadBuf_q  <= loadBuf_d;
      loadCnt_q  <= loadCnt_d;
      loadFull_q <= loadFull_d;
      latCnt_q   <= latCnt_d;
      outBuf_q   <= outBuf_d;
      drainIdx_q <= drainIdx_d;
    end
  end

  // out_data is forced to zero outside DRAIN so a stale captured batch never
  // shows on the output pins.
  always_comb begin
    bus.in_ready   = inReady;
    bus.net_start  = launch;
    bus.net_data_o = loadBuf_q;
    bus.out_valid  = draining;
    bus.out_data   = draining ? outBuf_q[drainIdx_q] : '0;
    bus.out_last   = draining && lastLane;
    bus.busy       = (state_q != IDLE) || (loadCnt_q != '0) || loadFull_q;
  end
endmodule

// File: tb/tb_bitonic_sort_ctrl.sv
// Self-checking bench for bitonic_sort_ctrl.
// A behavioural network (sort after NET_LAT cycles, garbage otherwise) feeds
// the DUT; expected sorted batches go into a scoreboard queue as each batch
// finishes loading and are popped by an output monitor. A second instance with
// INDEX=4, NET_LAT=1 covers the parameter sweep.
module tb_bitonic_sort_ctrl;
  localparam int WIDTH   = 8;
  localparam int INDEX   = 8;
  localparam int NET_LAT = 6;

  typedef logic [7:0] byteQ_t [$];

  logic clk;
  logic rst;

  bitonic_sort_ctrl_if #(.WIDTH(WIDTH), .INDEX(INDEX)) bus ();
  bitonic_sort_ctrl_if #(.WIDTH(WIDTH), .INDEX(4))     bus2 ();

  bitonic_sort_ctrl #(.WIDTH(WIDTH), .INDEX(INDEX), .NET_LAT(NET_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  bitonic_sort_ctrl #(.WIDTH(WIDTH), .INDEX(4), .NET_LAT(1)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  int nAssert = 0;
  int nFail   = 0;

  logic [7:0] stimQ [$];
  logic [7:0] expQ  [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic byteQ_t sortQ(byteQ_t q);
    byteQ_t     r;
    logic [7:0] tmp;
    r = q;
    for (int i = 0; i < r.size(); i++) begin
      for (int j = 0; j < r.size() - 1 - i; j++) begin
        if (r[j] > r[j+1]) begin
          tmp    = r[j];
          r[j]   = r[j+1];
          r[j+1] = tmp;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [63:0] sortVec8(logic [63:0] v);
    byteQ_t      q;
    byteQ_t      s;
    logic [63:0] res;
    for (int k = 0; k < 8; k++) q.push_back(v[k*8 +: 8]);
    s = sortQ(q);
    res = '0;
    for (int k = 0; k < 8; k++) res[k*8 +: 8] = s[k];
    return res;
  endfunction

  function automatic logic [31:0] sortVec4(logic [31:0] v);
    byteQ_t      q;
    byteQ_t      s;
    logic [31:0] res;
    for (int k = 0; k < 4; k++) q.push_back(v[k*8 +: 8]);
    s = sortQ(q);
    res = '0;
    for (int k = 0; k < 4; k++) res[k*8 +: 8] = s[k];
    return res;
  endfunction

  // Network models: the sorted vector appears exactly NET_LAT cycles after
  // net_start; every other cycle carries a garbage pattern.
  logic [63:0] netPipe [NET_LAT];
  logic [31:0] net2Q;

  always @(posedge clk) begin
    for (int i = NET_LAT - 1; i > 0; i--) netPipe[i] <= netPipe[i-1];
    netPipe[0] <= bus.net_start ? sortVec8(bus.net_data_o) : {8{8'hC3}};
    net2Q      <= bus2.net_start ? sortVec4(bus2.net_data_o) : {4{8'hC3}};
  end

  assign bus.net_data_i  = netPipe[NET_LAT-1];
  assign bus2.net_data_i = net2Q;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    nAssert++;
    assert (observed === expected)
    else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic pushSorted(input byteQ_t batch);
    byteQ_t s;
    s = sortQ(batch);
    foreach (s[k]) expQ.push_back(s[k]);
  endtask

  // Sends everything in stimQ, with in_valid dropped gapPct% of cycles.
  task automatic applyStimulus(input int gapPct);
    byteQ_t batch;
    int     budget;
    budget = 0;
    while (stimQ.size() > 0 && budget < 3000) begin
      bus.in_valid = ($urandom_range(99) >= gapPct);
      bus.in_data  = stimQ[0];
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) begin
        batch.push_back(stimQ.pop_front());
        if (batch.size() == INDEX) begin
          pushSorted(batch);
          batch.delete();
        end
      end
      @(posedge clk);
      #1;
      budget++;
    end
    bus.in_valid = 1'b0;
    checkOutput("stim_left", stimQ.size(), 0);
  endtask

  // Takes n output handshakes, with out_ready dropped stallPct% of cycles.
  task automatic drainOutputs(input int n, input int stallPct);
    int got;
    int budget;
    got    = 0;
    budget = 0;
    while (got < n && budget < 3000) begin
      bus.out_ready = ($urandom_range(99) >= stallPct);
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) got++;
      @(posedge clk);
      #1;
      budget++;
    end
    bus.out_ready = 1'b0;
    checkOutput("drain_count", got, n);
  endtask

  // Fixed timeline of the back-to-back two-batch run starting in cycle 0.
  task automatic timelineCheck();
    for (int t = 0; t <= 38; t++) begin
      @(negedge clk);
      checkOutput("tl_net_start", bus.net_start, (t == 8 || t == 23));
      checkOutput("tl_out_valid", bus.out_valid,
                  ((t >= 15 && t <= 22) || (t >= 30 && t <= 37)));
      checkOutput("tl_out_last", bus.out_last, (t == 22 || t == 37));
      checkOutput("tl_in_ready", bus.in_ready, !(t == 8 || (t >= 17 && t <= 23)));
      if (t == 8)  checkOutput("tl_lane0", bus.net_data_o[7:0], 8'd8);
      if (t == 0)  checkOutput("tl_busy0", bus.busy, 1'b0);
      if (t == 20) checkOutput("tl_busy20", bus.busy, 1'b1);
      if (t == 38) checkOutput("tl_busy38", bus.busy, 1'b0);
    end
  endtask

  // Scoreboard monitor plus stall-stability check.
  int         outCount = 0;
  logic       prevStall = 1'b0;
  logic [7:0] prevData  = '0;
  logic       prevLast  = 1'b0;
  logic [7:0] expByte;

  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (prevStall) begin
        checkOutput("stall_data", bus.out_data, prevData);
        checkOutput("stall_last", bus.out_last, prevLast);
      end
      if (bus.out_ready) begin
        checkOutput("out_expected", (expQ.size() != 0), 1'b1);
        if (expQ.size() != 0) begin
          expByte = expQ.pop_front();
          checkOutput("out_data", bus.out_data, expByte);
          checkOutput("out_last", bus.out_last, (outCount % INDEX) == INDEX - 1);
          outCount <= outCount + 1;
        end
      end
    end
    prevStall <= !rst && bus.out_valid && !bus.out_ready;
    prevData  <= bus.out_data;
    prevLast  <= bus.out_last;
  end

  logic [7:0] p4In  [4];
  logic [7:0] p4Exp [4];
  int         p4Got;

  initial begin
    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.out_ready  = 1'b0;
    bus2.in_valid  = 1'b0;
    bus2.in_data   = '0;
    bus2.out_ready = 1'b0;
    p4In  = '{8'd30, 8'd10, 8'd40, 8'd20};
    p4Exp = '{8'd10, 8'd20, 8'd30, 8'd40};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("rst_in_ready", bus.in_ready, 1'b0);
    checkOutput("rst_net_start", bus.net_start, 1'b0);
    checkOutput("rst_out_valid", bus.out_valid, 1'b0);
    checkOutput("rst_out_last", bus.out_last, 1'b0);
    checkOutput("rst_busy", bus.busy, 1'b0);
    checkOutput("rst_out_data", bus.out_data, 8'h00);
    checkOutput("rst_net_data", bus.net_data_o, 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_in_ready", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;

    // Directed 8..1 followed back-to-back by a second batch
    $display("[TB] back-to-back directed batches");
    for (int v = 8; v >= 1; v--) stimQ.push_back(8'(v));
    foreach (p4In[k]) stimQ.push_back(8'(8'd100 - p4In[k]));
    for (int v = 0; v < 4; v++) stimQ.push_back(8'(8'd200 + v * 13));
    fork
      applyStimulus(0);
      drainOutputs(16, 0);
      timelineCheck();
    join
    @(posedge clk);
    #1;

    // Random input gaps and output stalls
    $display("[TB] random gaps and stalls");
    for (int k = 0; k < 4 * INDEX; k++) stimQ.push_back(8'($urandom_range(255)));
    fork
      applyStimulus(50);
      drainOutputs(4 * INDEX, 50);
    join
    repeat (2) @(posedge clk);
    #1;

    // Boundary values
    $display("[TB] boundary values");
    for (int k = 0; k < 8; k++) stimQ.push_back((k % 2 == 0) ? 8'hFF : 8'h00);
    for (int k = 0; k < 8; k++) stimQ.push_back(8'h5A);
    fork
      applyStimulus(0);
      drainOutputs(16, 0);
    join
    repeat (2) @(posedge clk);
    #1;

    // Reset while a batch is in RUN; its network result must never appear
    $display("[TB] reset during RUN");
    for (int k = 0; k < 8; k++) stimQ.push_back(8'(8'd90 + k * 7));
    applyStimulus(0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    expQ.delete();
    @(negedge clk);
    checkOutput("midrst_in_ready", bus.in_ready, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    checkOutput("midrst_out_valid", bus.out_valid, 1'b0);
    checkOutput("midrst_busy", bus.busy, 1'b0);
    checkOutput("midrst_in_ready1", bus.in_ready, 1'b1);
    repeat (12) @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    stimQ = '{8'd200, 8'd3, 8'd77, 8'd3, 8'd150, 8'd0, 8'd255, 8'd64};
    fork
      applyStimulus(0);
      drainOutputs(8, 0);
    join
    checkOutput("sb_empty", expQ.size(), 0);

    // INDEX=4, NET_LAT=1 instance
    $display("[TB] parameter sweep INDEX=4 NET_LAT=1");
    bus2.in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus2.in_data = p4In[k];
      @(negedge clk);
      checkOutput("p4_in_ready", bus2.in_ready, 1'b1);
      @(posedge clk);
      #1;
    end
    bus2.in_valid  = 1'b0;
    bus2.out_ready = 1'b1;
    p4Got = 0;
    for (int c = 4; c < 30 && p4Got < 4; c++) begin
      @(negedge clk);
      if (bus2.out_valid) begin
        if (p4Got == 0) checkOutput("p4_first_valid_gap", c - 3, 3);
        checkOutput("p4_data", bus2.out_data, p4Exp[p4Got]);
        checkOutput("p4_last", bus2.out_last, p4Got == 3);
        p4Got++;
      end
      @(posedge clk);
      #1;
    end
    checkOutput("p4_count", p4Got, 4);
    bus2.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end
endmodule
